// File: rtl/spi_bus_arbiter_pkg.sv
// spi_bus_arbiter_pkg: shared FSM encoding, requester indices and EEPROM opcode
package spi_bus_arbiter_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_LAUNCH, ST_WAIT, ST_GAP} state_t;
    localparam logic REQ_EEPROM = 1'b0;
    localparam logic REQ_HC595 = 1'b1;
    localparam logic [7:0] OP_EEPROM_READ = 8'h03;
endpackage

// File: rtl/spi_arb_pick2.sv
// spi_arb_pick2: two-way grant picker; on a tie the requester not named by ptr wins
module spi_arb_pick2
    import spi_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    // A lone request wins outright; a tie goes away from the last winner
    always_comb begin
        gnt = req;
        if (&req) gnt = (ptr == REQ_HC595) ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one SPI engine between two burst requesters; define SPI_ARB_ROUND_ROBIN_EN for round-robin ties, else requester 0 has fixed priority
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int CS_GAP = 2,
    parameter int LEN_W  = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             req0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [7:0]       din0,
    input  logic [7:0]       din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [7:0]       rx_data,
    output logic [1:0]       cs_n,
    output logic             eng_send_request,
    output logic [7:0]       eng_din,
    input  logic             eng_processing,
    input  logic             eng_data_valid,
    input  logic [7:0]       eng_dout
);
    state_t           state, state_n;
    logic [LEN_W:0]   cnt;
    logic [3:0]       gap_cnt;
    logic [1:0]       pick;
    logic [LEN_W-1:0] len_sel;
    logic             sel, ptr, dv_q, ack_r, done_r, send_r;
    logic             busy, grant, launch, rise, req_sel;

    spi_arb_pick2 u_pick (
        .req ({req1, req0}),
        .ptr (ptr),
        .gnt (pick)
    );

`ifdef SPI_ARB_ROUND_ROBIN_EN
    // Remember the last winner so the next tie goes to the other requester
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) ptr <= REQ_HC595;
        else if (grant) ptr <= pick[REQ_HC595];
`else
    assign ptr = REQ_HC595;
`endif

    // Decode strobes from the current state and choose the next state
    always_comb begin
        busy    = state inside {ST_SETUP, ST_LAUNCH, ST_WAIT};
        req_sel = sel ? req1 : req0;
        len_sel = pick[REQ_HC595] ? len1 : len0;
        grant   = state == ST_IDLE && (req0 || req1);
        launch  = state == ST_LAUNCH && !eng_processing;
        rise    = state == ST_WAIT && !ack_r && eng_data_valid && !dv_q;
        state_n = state;
        case (state)
            ST_IDLE:   state_n = grant ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_n = ST_LAUNCH;
            ST_LAUNCH: state_n = launch ? ST_WAIT : ST_LAUNCH;
            ST_WAIT:   state_n = !ack_r ? ST_WAIT : (cnt != '0 && req_sel) ? ST_LAUNCH : ST_GAP;
            ST_GAP:    state_n = gap_cnt == '0 ? ST_IDLE : ST_GAP;
            default:   state_n = ST_IDLE;
        endcase
    end

    // State, byte counter, gap timer, engine handshake and received data
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            sel     <= REQ_EEPROM;
            dv_q    <= 1'b0;
            ack_r   <= 1'b0;
            done_r  <= 1'b0;
            send_r  <= 1'b0;
            eng_din <= '0;
            rx_data <= '0;
        end else begin
            state   <= state_n;
            dv_q    <= eng_data_valid;
            ack_r   <= rise;
            done_r  <= state == ST_WAIT && state_n == ST_GAP;
            send_r  <= launch;
            gap_cnt <= (state == ST_GAP) ? gap_cnt - 4'd1 : 4'(CS_GAP - 1);
            if (grant) begin
                sel <= pick[REQ_HC595];
                cnt <= (len_sel == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_sel};
            end
            if (launch) eng_din <= sel ? din1 : din0;
            if (rise) begin
                rx_data <= eng_dout;
                cnt     <= cnt - (LEN_W+1)'(1);
            end
        end
    end

    assign gnt0             = busy && sel == REQ_EEPROM;
    assign gnt1             = busy && sel == REQ_HC595;
    assign cs_n             = {~gnt1, ~gnt0};
    assign ack0             = ack_r && sel == REQ_EEPROM;
    assign ack1             = ack_r && sel == REQ_HC595;
    assign done0            = done_r && sel == REQ_EEPROM;
    assign done1            = done_r && sel == REQ_HC595;
    assign eng_send_request = send_r;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: vector table, directed corner cases and random bursts against a burst-level model
module tb_spi_bus_arbiter;
    localparam int CS_GAP = 2;
    localparam int LEN_W  = 8;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit r0, r1;
        int l0, l1, lat, ew, ea;
    } vec_t;

    logic             clk;
    logic             nreset = 0;
    logic             req0 = 0, req1 = 0;
    logic [LEN_W-1:0] len0 = 0, len1 = 0;
    logic [7:0]       din0 = 0, din1 = 0;
    logic             gnt0, gnt1, ack0, ack1, done0, done1;
    logic [7:0]       rx_data, eng_din;
    logic [1:0]       cs_n;
    logic             eng_send_request;
    logic             eng_processing = 0, eng_data_valid = 0;
    logic [7:0]       eng_dout = 0, eng_byte = 0;

    int n_cmp = 0, n_fail = 0;
    int eng_lat = 4, busy_cnt = 0;
    int ack_cnt[2] = '{0, 0};
    int done_total = 0;
    int gq[$];
    bit in_burst = 0, exp_done = 0;
    int g = 0, remain = 0, last_gnt = 1, since_done = 1000;
    logic [1:0] prev_req = 0, prev_gnt = 0, prev_ack = 0;
    logic prev_send = 0;
    vec_t tv[8];

    spi_bus_arbiter #(.CS_GAP(CS_GAP), .LEN_W(LEN_W)) dut (
        .clk              (clk),
        .nreset           (nreset),
        .req0             (req0),
        .req1             (req1),
        .len0             (len0),
        .len1             (len1),
        .din0             (din0),
        .din1             (din1),
        .gnt0             (gnt0),
        .gnt1             (gnt1),
        .ack0             (ack0),
        .ack1             (ack1),
        .done0            (done0),
        .done1            (done1),
        .rx_data          (rx_data),
        .cs_n             (cs_n),
        .eng_send_request (eng_send_request),
        .eng_din          (eng_din),
        .eng_processing   (eng_processing),
        .eng_data_valid   (eng_data_valid),
        .eng_dout         (eng_dout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d0, input int lim);
        for (int i = 0; i < lim && done_total == d0; i++) @(posedge clk);
        #1;
        chk("done_timeout", int'(done_total > d0), 1);
    endtask

    task automatic run_burst(input bit r0, input bit r1, input int l0, input int l1, input int lat,
                             output int winner, output int nacks);
        int a0, a1, d0, q0;
        len0 = LEN_W'(l0);
        len1 = LEN_W'(l1);
        eng_lat = lat;
        din0 = 8'($urandom);
        din1 = 8'($urandom);
        a0 = ack_cnt[0];
        a1 = ack_cnt[1];
        d0 = done_total;
        q0 = gq.size();
        req0 = r0;
        req1 = r1;
        wait_done(d0, 6000);
        req0 = 0;
        req1 = 0;
        tick(CS_GAP + 8);
        winner = (gq.size() > q0) ? gq[q0] : -1;
        nacks = ack_cnt[0] - a0 + ack_cnt[1] - a1;
    endtask

    // Engine: busy for eng_lat cycles per byte, then holds data_valid high until the next launch
    always @(posedge clk) begin
        if (eng_send_request) begin
            eng_processing <= 1;
            eng_data_valid <= 0;
            busy_cnt <= eng_lat;
            eng_byte <= eng_din;
        end else if (eng_processing) begin
            if (busy_cnt <= 1) begin
                eng_processing <= 0;
                eng_data_valid <= 1;
                eng_dout <= eng_byte ^ 8'h5A;
            end
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Burst-level reference: who wins, how many bytes, when done must appear
    always @(negedge clk) begin : mon
        logic [1:0] cg, ca, cd, exp_cs;
        int w, l;
        cg = {gnt1, gnt0};
        ca = {ack1, ack0};
        cd = {done1, done0};
        if (!nreset) begin
            in_burst = 0;
            exp_done = 0;
            last_gnt = 1;
            since_done = 1000;
            prev_gnt = 0;
            prev_ack = 0;
            prev_send = 0;
            prev_req = {req1, req0};
            chk("reset_cs_n", cs_n, 3);
            chk("reset_pulses", {gnt1, gnt0, ack1, ack0, done1, done0, eng_send_request}, 0);
        end else begin
            exp_cs = ~cg;
            chk("gnt_onehot", int'(cg != 2'b11), 1);
            chk("cs_n_vs_gnt", cs_n, exp_cs);
            chk("done", cd, exp_done ? (g ? 2 : 1) : 0);
            if (cd != 0) done_total++;
            if (exp_done) begin
                in_burst = 0;
                since_done = 0;
                exp_done = 0;
            end
            if (cg != 0 && prev_gnt == 0) begin
                w = (prev_req == 2'b11) ? (RR ? 1 - last_gnt : 0) : (prev_req[1] ? 1 : 0);
                chk("grant_winner", cg, w ? 2 : 1);
                chk("grant_gap", int'(since_done >= CS_GAP + 1), 1);
                in_burst = 1;
                g = w;
                last_gnt = w;
                gq.push_back(w);
                l = int'(w ? len1 : len0);
                remain = (l == 0) ? (1 << LEN_W) : l;
            end
            chk("gnt_state", cg, in_burst ? (g ? 2 : 1) : 0);
            if (ca != 0) begin
                chk("ack_owner", ca, g ? 2 : 1);
                chk("ack_in_burst", in_burst, 1);
                chk("ack_single", int'(prev_ack != 0), 0);
                chk("rx_data", rx_data, (g ? din1 : din0) ^ 8'h5A);
                if (ca[0]) ack_cnt[0]++;
                if (ca[1]) ack_cnt[1]++;
                remain--;
                exp_done = remain == 0 || !(g ? req1 : req0);
            end
            if (eng_send_request) begin
                chk("eng_din_launch", eng_din, g ? din1 : din0);
                chk("send_single", prev_send, 0);
            end
            if (eng_processing && in_burst) chk("eng_din_stable", eng_din, g ? din1 : din0);
            if (since_done < 1000) since_done++;
            prev_gnt = cg;
            prev_ack = ca;
            prev_send = eng_send_request;
            prev_req = {req1, req0};
        end
    end

    initial begin
        int w, n, a0, d0, q0;
        tv[0] = '{1, 0, 4, 0, 8, 0, 4};
        tv[1] = '{0, 1, 0, 3, 2, 1, 3};
        tv[2] = '{1, 1, 1, 1, 3, 0, 1};
        tv[3] = '{1, 1, 1, 1, 3, RR ? 1 : 0, 1};
        tv[4] = '{1, 1, 1, 1, 3, 0, 1};
        tv[5] = '{1, 1, 1, 1, 3, RR ? 1 : 0, 1};
        tv[6] = '{0, 1, 0, 0, 1, 1, 256};
        tv[7] = '{1, 0, 1, 0, 5, 0, 1};

        tick(3);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_eng_din", eng_din, 0);
        chk("reset_cs_n_init", cs_n, 3);
        nreset = 1;
        tick(2);

        len0 = 1;
        len1 = 1;
        eng_lat = 3;
        din0 = 8'h11;
        din1 = 8'h22;
        q0 = gq.size();
        req0 = 1;
        req1 = 1;
        for (int i = 0; i < 600 && gq.size() < q0 + 4; i++) @(posedge clk);
        d0 = done_total;
        #1;
        req0 = 0;
        req1 = 0;
        chk("held_grant_count", int'(gq.size() >= q0 + 4), 1);
        for (int i = 0; i < 4; i++)
            if (gq.size() > q0 + i) chk($sformatf("held_order%0d", i), gq[q0 + i], RR ? i % 2 : 0);
        wait_done(d0, 200);
        tick(CS_GAP + 6);

        for (int i = 0; i < 8; i++) begin
            run_burst(tv[i].r0, tv[i].r1, tv[i].l0, tv[i].l1, tv[i].lat, w, n);
            chk($sformatf("vec%0d_winner", i), w, tv[i].ew);
            chk($sformatf("vec%0d_acks", i), n, tv[i].ea);
        end

        a0 = ack_cnt[0];
        d0 = done_total;
        len0 = 10;
        eng_lat = 4;
        req0 = 1;
        for (int i = 0; i < 500 && ack_cnt[0] < a0 + 2; i++) @(posedge clk);
        #1;
        req0 = 0;
        wait_done(d0, 500);
        tick(CS_GAP + 6);
        chk("drop_acks", ack_cnt[0] - a0, 3);
        chk("drop_dones", done_total - d0, 1);

        a0 = ack_cnt[0];
        len0 = 5;
        eng_lat = 8;
        req0 = 1;
        for (int i = 0; i < 500 && ack_cnt[0] < a0 + 1; i++) @(posedge clk);
        for (int i = 0; i < 100 && !eng_processing; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        nreset = 0;
        #1;
        chk("async_cs_n", cs_n, 3);
        chk("async_gnt0", gnt0, 0);
        d0 = done_total;
        req0 = 0;
        @(posedge clk);
        #1;
        nreset = 1;
        tick(12);
        chk("reset_no_done", done_total - d0, 0);
        run_burst(1, 0, 2, 0, 4, w, n);
        chk("post_reset_winner", w, 0);
        chk("post_reset_acks", n, 2);

        for (int it = 0; it < 40; it++) begin
            int r;
            bit drop;
            r = int'($urandom_range(1, 3));
            len0 = LEN_W'($urandom_range(1, 5));
            len1 = LEN_W'($urandom_range(1, 5));
            eng_lat = int'($urandom_range(1, 6));
            din0 = 8'($urandom);
            din1 = 8'($urandom);
            drop = $urandom_range(0, 3) == 0;
            q0 = gq.size();
            d0 = done_total;
            req0 = r[0];
            req1 = r[1];
            for (int i = 0; i < 50 && gq.size() == q0; i++) @(posedge clk);
            #1;
            chk("rand_grant_seen", int'(gq.size() > q0), 1);
            if (drop) begin
                tick(int'($urandom_range(0, 3)));
                req0 = 0;
                req1 = 0;
            end
            wait_done(d0, 1000);
            req0 = 0;
            req1 = 0;
            tick(CS_GAP + 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter CS_GAP, default 2, is the number of clk cycles both chip selects stay high between bursts (legal range 1..15).
REQ-002 Parameter LEN_W, default 8, is the width of the burst-length inputs.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 req0 / req1  input  1  burst request from requester 0 (EEPROM loader) and requester 1 (HC595 driver).
REQ-006 len0 / len1  input  LEN_W  burst length in bytes; sampled at grant.
REQ-007 din0 / din1  input  8  next byte to transmit; sampled at each byte launch.
REQ-008 gnt0 / gnt1  output  1  grant, high from grant cycle through the last cycle of the burst.
REQ-009 ack0 / ack1  output  1  one-cycle pulse per completed byte; rx_data is valid in that cycle.
REQ-010 done0 / done1  output  1  one-cycle pulse in the cycle after the final ack of a burst.
REQ-011 rx_data  output  8  last received byte, shared by both requesters.
REQ-012 cs_n  output  2  chip select per requester, active low.
REQ-013 eng_send_request  output  1  one-cycle launch pulse to the SPI engine.
REQ-014 eng_din  output  8  byte to the engine; held stable while eng_processing is high.
REQ-015 eng_processing  input  1  engine busy flag.
REQ-016 eng_data_valid  input  1  engine byte-complete level.
REQ-017 eng_dout  input  8  engine received byte.

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP, LAUNCH, WAIT and GAP.
REQ-019 IDLE -> SETUP when any req is high: assert gnt and cs_n of the winner, latch its len into a byte counter, then go to LAUNCH after one SETUP cycle.
REQ-020 LAUNCH: when eng_processing is low, pulse eng_send_request, drive eng_din from the granted din, then go to WAIT.
REQ-021 WAIT: on a rising edge of eng_data_valid, detected as a 0->1 change against a registered copy, capture eng_dout into rx_data, pulse ack, and decrement the counter.
REQ-022 After the ack, if the counter is nonzero and the granted req is still high, go to LAUNCH; otherwise pulse done, deassert gnt and cs_n, and go to GAP.
REQ-023 GAP SHALL hold both cs_n high for exactly CS_GAP cycles, then go to IDLE.
REQ-024 len == 0 SHALL be treated as 2^LEN_W bytes.
REQ-025 Dropping req mid-burst SHALL NOT abort the in-flight byte; the burst ends at the next byte boundary with done.
REQ-026 Simultaneous req0 and req1 SHALL be resolved per the Configuration section; arbitration happens only in IDLE, never mid-burst.
REQ-027 At most one gnt and at most one cs_n low at any time; the ack, done and eng_send_request pulses SHALL never exceed one cycle.
REQ-028 A new req that arrives during GAP SHALL wait for IDLE; a request is granted no earlier than 1 cycle after it is seen.

Reset
REQ-029 Asynchronous nreset low SHALL force: state IDLE, cs_n=2'b11, gnt/ack/done/eng_send_request=0, rx_data=0, eng_din=0, counter=0, round-robin pointer=requester 1 (so requester 0 wins first).
REQ-030 Reset mid-burst SHALL release cs_n immediately and emit no done; the engine's own reset is not driven by this block.

Configuration
REQ-031 Macro SPI_ARB_ROUND_ROBIN_EN defined: on a simultaneous request the requester not granted last wins, and the pointer updates at each grant.
REQ-032 Macro SPI_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins, and no pointer register exists.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding, the requester index constants REQ_EEPROM=0 and REQ_HC595=1, and the EEPROM READ opcode 8'h03.
REQ-034 Grant selection SHALL be a sub-module spi_arb_pick2 (two requests, pointer, grant one-hot); the FSM, counter and edge detect stay in the top.

Verification
REQ-035 Reset, then req0=1 with len0=4 and engine model 8-cycle bytes: exactly 4 ack0 pulses, 1 done0, cs_n[0] low throughout, cs_n=2'b11 for 2 cycles afterward.
REQ-036 req0 and req1 both high with len=1, round robin enabled: grant order 0,1,0,1 over 4 bursts; with the macro undefined: 0,0,0,0 while req0 is held.
REQ-037 req1 with len1=0: 256 ack1 pulses, then done1.
REQ-038 req0 dropped after the 2nd ack of len0=10: the 3rd byte completes, then done0; 3 acks total.
REQ-039 nreset asserted in WAIT of byte 2: cs_n=2'b11 within the same cycle (asynchronously), no done, and the next req0 is granted normally.
REQ-040 A rising edge of eng_data_valid held high for 5 cycles: exactly one ack; eng_din stable while eng_processing is high.
